// File: rtl/uart_tx_periph_if.sv
// CPU data-bus slave port of the UART transmitter: command in, one-cycle read response out.
interface uart_tx_periph_if;
    logic        mem_cmd_sel;
    logic        mem_cmd_valid;
    logic        mem_cmd_wr;
    logic [11:0] mem_cmd_addr;
    logic [31:0] mem_cmd_wdata;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_rdata;

    modport master (
        output mem_cmd_sel, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata,
        input  mem_rsp_ready, mem_rsp_rdata
    );

    modport slave (
        input  mem_cmd_sel, mem_cmd_valid, mem_cmd_wr, mem_cmd_addr, mem_cmd_wdata,
        output mem_rsp_ready, mem_rsp_rdata
    );
endinterface

// File: rtl/uart_tx_periph.sv
// Bus-mapped 8N1 UART transmitter with TX FIFO; parity bit optional under UART_TX_PARITY_EN.
// Read data one cycle after the command; no write backpressure, DATA writes while full are dropped and flag overflow.
module uart_tx_periph #(
    parameter int          FIFO_DEPTH     = 8,
    parameter logic [15:0] BAUD_DIV_RESET = 16'd433
) (
    input  logic              clk,
    input  logic              reset_,
    uart_tx_periph_if.slave   bus,
    output logic              txd
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [9:0] REG_DATA   = 10'd0;
    localparam logic [9:0] REG_STATUS = 10'd1;
    localparam logic [9:0] REG_BAUD   = 10'd2;

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    state_t             state_q, state_d;
    logic [7:0]         shift_q, shift_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [15:0]        timer_q, timer_d;
    logic               txd_q, txd_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ovf_q, ovf_d;
    logic [15:0]        baud_q, baud_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic [31:0]        rsp_dat_q, rsp_dat_d;
    logic [7:0]         fifo_mem_q [FIFO_DEPTH];
`ifdef UART_TX_PARITY_EN
    logic               par_en_q, par_en_d, par_odd_q, par_odd_d, par_q, par_d;
`endif

    logic        cmd_take, cmd_rd, cmd_wr_data, cmd_wr_status, cmd_wr_baud;
    logic [9:0]  cmd_word;
    logic        fifo_full, fifo_empty, fifo_push, fifo_pop, start_frame, bit_end;
    logic [7:0]  fifo_head;
    logic [31:0] status_word, baud_word;
    logic        unused_ok;

    assign cmd_take      = bus.mem_cmd_valid & bus.mem_cmd_sel;
    assign cmd_word      = bus.mem_cmd_addr[11:2];
    assign cmd_rd        = cmd_take & ~bus.mem_cmd_wr;
    assign cmd_wr_data   = cmd_take & bus.mem_cmd_wr & (cmd_word == REG_DATA);
    assign cmd_wr_status = cmd_take & bus.mem_cmd_wr & (cmd_word == REG_STATUS);
    assign cmd_wr_baud   = cmd_take & bus.mem_cmd_wr & (cmd_word == REG_BAUD);

    // Full is the pre-pop view: a pop in the same cycle never rescues a write.
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign fifo_empty = (level_q == '0);
    assign fifo_push  = cmd_wr_data & ~fifo_full;
    assign fifo_head  = fifo_mem_q[rd_ptr_q];

    assign status_word = {17'd0, 7'(level_q), 4'd0, ovf_q, fifo_empty, fifo_full, state_q != ST_IDLE};
`ifdef UART_TX_PARITY_EN
    assign baud_word   = {14'd0, par_odd_q, par_en_q, baud_q};
`else
    assign baud_word   = {16'd0, baud_q};
`endif
    assign unused_ok   = ^{bus.mem_cmd_addr[1:0], bus.mem_cmd_wdata[31:16]};

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        timer_d     = timer_q;
        start_frame = 1'b0;
        fifo_pop    = 1'b0;
        bit_end     = (timer_q == 16'd0);
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif
        // Divider is re-read only at bit boundaries, so a new BAUD_DIV never truncates a bit.
        if (state_q != ST_IDLE) timer_d = bit_end ? baud_q : timer_q - 16'd1;
        case (state_q)
            ST_IDLE:  start_frame = !fifo_empty;
            ST_START: if (bit_end) state_d = ST_DATA;
            ST_DATA: begin
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q - 3'd1;
                    if (bit_cnt_q == 3'd0) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                        par_d   = par_q ^ par_odd_q;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (bit_end) state_d = ST_STOP;
`endif
            ST_STOP: begin
                if (bit_end) begin
                    state_d     = ST_IDLE;
                    start_frame = !fifo_empty;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (start_frame) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_head;
            bit_cnt_d = 3'd7;
            timer_d   = baud_q;
            state_d   = ST_START;
`ifdef UART_TX_PARITY_EN
            par_d     = ^fifo_head;
`endif
        end
        // txd is registered from the next state so the line never glitches.
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_d = par_d;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        baud_d    = baud_q;
        rsp_vld_d = cmd_rd;
        rsp_dat_d = 32'd0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_odd_d = par_odd_q;
`endif
        if (fifo_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (fifo_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (fifo_push && !fifo_pop)      level_d = level_q + LVL_W'(1);
        else if (!fifo_push && fifo_pop) level_d = level_q - LVL_W'(1);
        if (cmd_wr_status && bus.mem_cmd_wdata[3]) ovf_d = 1'b0;
        if (cmd_wr_data && fifo_full)              ovf_d = 1'b1;
        if (cmd_wr_baud) begin
            baud_d    = bus.mem_cmd_wdata[15:0];
`ifdef UART_TX_PARITY_EN
            par_en_d  = bus.mem_cmd_wdata[16];
            par_odd_d = bus.mem_cmd_wdata[17];
`endif
        end
        if (cmd_rd) begin
            case (cmd_word)
                REG_STATUS: rsp_dat_d = status_word;
                REG_BAUD:   rsp_dat_d = baud_word;
                default:    rsp_dat_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem_q[wr_ptr_q] <= bus.mem_cmd_wdata[7:0];
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q   <= ST_IDLE;
            shift_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
            timer_q   <= 16'd0;
            txd_q     <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= 1'b0;
            baud_q    <= BAUD_DIV_RESET;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= 32'd0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            timer_q   <= timer_d;
            txd_q     <= txd_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            baud_q    <= baud_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            par_q     <= par_d;
`endif
        end
    end

    assign bus.mem_rsp_ready = rsp_vld_q;
    assign bus.mem_rsp_rdata = rsp_dat_q;
    assign txd               = txd_q;
endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped UART transmitter on the CPU data bus, decoded at 0xF0001000–0xF0001FFF.
- The decoder drives mem_cmd_sel; rsp ready/rdata are muxed back alongside the RAM and GPIO slaves.
- Bytes written by the CPU enter a TX FIFO and are serialized 8N1, LSB first, on txd.
- The bus gives no write backpressure (mem_cmd_ready is tied 1), so writes to a full FIFO are dropped and flagged.

Parameters:
- FIFO_DEPTH, 8: TX FIFO entries; power of 2, range 2..64.
- BAUD_DIV_RESET, 16'd433: reset value of BAUD_DIV (115200 baud @ 50 MHz).

Ports:
- clk  in  1  system clock
- reset_  in  1  asynchronous active-low reset
- mem_cmd_sel  in  1  address decode hit for this slave
- mem_cmd_valid  in  1  bus command valid
- mem_cmd_wr  in  1  1=write, 0=read
- mem_cmd_addr  in  12  byte offset within the 4 KB window
- mem_cmd_wdata  in  32  write data
- mem_rsp_ready  out  1  read data valid pulse
- mem_rsp_rdata  out  32  read data
- txd  out  1  serial output, idle high

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on reset_ (polarity and synchronicity fixed). Reset is asserted asynchronously and released synchronously to clk.
- Reset values: txd=1, mem_rsp_ready=0, mem_rsp_rdata=0, FIFO empty, overflow=0, BAUD_DIV=BAUD_DIV_RESET, state=IDLE.
- Command acceptance: a command is taken when mem_cmd_valid & mem_cmd_sel. Decode uses addr[11:2]; addr[1:0] are ignored.
- 0x000 DATA, W: pushes wdata[7:0]. Reads as 0.
- 0x004 STATUS, R:
  - bit0 busy (state!=IDLE)
  - bit1 full
  - bit2 empty
  - bit3 overflow (sticky)
  - bits[14:8] FIFO level
- 0x004 STATUS, W: writing 1 to bit3 clears overflow; other bits are ignored.
- 0x008 BAUD_DIV, R/W: bits[15:0]; upper bits read 0. Bit period = BAUD_DIV+1 clocks, so BAUD_DIV=0 gives a 1-clock bit.
- Other offsets: reads return 0; writes are ignored.
- Read timing: mem_rsp_ready=1 for exactly one cycle, the cycle after the read command, with rdata valid in that cycle.
- Between reads: rdata returns to 0 in every cycle where mem_rsp_ready=0.
- Writes: produce no response.
- Push on full: full is sampled before any same-cycle pop. A write to DATA while full is dropped, sets overflow, and leaves FIFO contents unchanged. This holds even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: both happen and the level is unchanged. Pointers wrap modulo FIFO_DEPTH.
- Overflow set and clear in the same cycle: set wins.
- TX FSM overview: IDLE -> START -> DATA -> STOP -> IDLE.
- IDLE: txd=1. If the FIFO is non-empty, pop the head into the shift register, load the bit counter, and enter START on the next cycle. The pop is visible in STATUS one cycle after the pop cycle.
- START: txd=0 for one bit period.
- DATA: txd=shift[0], shift right each period, 8 periods.
- STOP: txd=1 for one period. Then go to IDLE; if the FIFO is non-empty, pop that same cycle so frames are back-to-back with no extra idle.
- Bit timer: down-counter loaded with BAUD_DIV at each bit start. The bit ends when the counter reaches 0.
- BAUD_DIV changes mid-frame: take effect at the next bit boundary. The current bit is never truncated.
- Frame length: 10*(BAUD_DIV+1) clocks from START entry to IDLE re-entry.
- Reset mid-frame: txd=1 immediately (async), FIFO flushed, frame lost.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined, BAUD_DIV bit16 is PAR_EN and bit17 is PAR_ODD, both reset 0.
- With PAR_EN=1, a PARITY state is inserted between DATA and STOP. txd = XOR of the data bits, inverted when PAR_ODD=1. Frame length becomes 11 periods.
- When undefined: bits 16/17 read 0 and writes to them are ignored; frames are always 10 periods.

Test Plan:
- Reset, then read 0x004 -> rsp one cycle later = 0x00000004; read 0x008 -> 0x000001B1; txd=1.
- BAUD_DIV=3, write DATA=0x55 -> txd is 0 for 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, then 1 for 4 clocks. busy deasserts 40 clocks after START entry.
- BAUD_DIV=3, 10 back-to-back DATA writes 0x01..0x0A, FIFO_DEPTH=8:
  - 0x01 goes to the shifter; 0x02..0x09 fill the FIFO; 0x0A is dropped.
  - STATUS=0x0000080B (level 8, overflow, full, busy).
  - 9 frames are emitted with no idle gaps between them.
- Write 0x008 to STATUS, then read STATUS -> overflow=0. Reads of 0x010 and 0xFFC return 0, with mem_rsp_ready pulsed for 1 cycle each.
- Mid-frame BAUD_DIV change from 3 to 7 during bit 2 -> bit 2 lasts 4 clocks and later bits last 8 clocks.
- Assert reset_ during the DATA state -> txd=1 asynchronously. After release, STATUS=0x00000004 and no residual frame is sent.
